// File: rtl/posit_decode_pipe_if.sv
// -----------------------------------------------------------------------------
// posit_decode_pipe_if
//   Valid/ready bus between a producer of packed posit words and the
//   posit_decode_pipe decoder, plus the decoded result stream.
//
//   Parameters: W (word width), ES_FULL (exponent bits in full-width mode).
//   EXP_L / MANT_L are derived here so both ends agree on slot widths.
//
//   Input side : in_valid, in_ready, in_data[W], in_mode[2]
//   Output side: out_valid, out_ready, out_mode[2], out_sign[4], out_zero[4],
//                out_nar[4], out_exp[4*EXP_L], out_mant[4*MANT_L], out_err
//
//   master : the environment (drives words, accepts results)
//   slave  : the decoder
// -----------------------------------------------------------------------------
interface posit_decode_pipe_if #(
  parameter int W       = 32,
  parameter int ES_FULL = 6
);
  localparam int EXP_L  = ES_FULL + $clog2(W) + 1;
  localparam int MANT_L = W - 1 - ES_FULL;

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic [1:0]            in_mode;

  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_mode;
  logic [3:0]            out_sign;
  logic [3:0]            out_zero;
  logic [3:0]            out_nar;
  logic [4*EXP_L-1:0]    out_exp;
  logic [4*MANT_L-1:0]   out_mant;
  logic                  out_err;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_mode, out_sign, out_zero, out_nar,
           out_exp, out_mant, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_mode, out_sign, out_zero, out_nar,
           out_exp, out_mant, out_err
  );
endinterface

// File: rtl/posit_decode_pipe.sv
// -----------------------------------------------------------------------------
// posit_decode_pipe
//   Two-stage valid/ready posit field decoder. Each W-bit word carries one
//   full-width, two half-width or four quarter-width posits (in_mode 0/1/2;
//   mode 3 is illegal and flows through with out_err=1 and all slots 0).
//
//   Stage 1: per-lane sign, zero/NaR flags and two's-complement magnitude.
//   Stage 2: leading-run (regime) detect, shift past regime + terminator,
//            signed exponent = regime*2^ES + es_bits, mantissa with hidden bit
//            MSB-justified in MANT_L.
//
//   Ports: clk, rst (synchronous, active high), bus (posit_decode_pipe_if.slave)
//   Optional (macro POSIT_DECODE_STATS_EN): stat_zero_cnt, stat_nar_cnt,
//   stat_err_cnt -- 16-bit saturating counters updated on each out transfer.
// -----------------------------------------------------------------------------
module posit_decode_pipe #(
  parameter int W        = 32,
  parameter int ES_FULL  = 6,
  parameter int ES_HALF  = 4,
  parameter int ES_QUART = 2
) (
  input  logic               clk,
  input  logic               rst,
  posit_decode_pipe_if.slave bus
`ifdef POSIT_DECODE_STATS_EN
  ,
  output logic [15:0]        stat_zero_cnt,
  output logic [15:0]        stat_nar_cnt,
  output logic [15:0]        stat_err_cnt
`endif
);
  localparam int EXP_L  = ES_FULL + $clog2(W) + 1;
  localparam int MANT_L = W - 1 - ES_FULL;
  localparam int HW     = W / 2;
  localparam int QW     = W / 4;

  // Decodes one lane body (lane without its sign bit), MSB-justified in W-1
  // bits and zero-padded below. The padding never extends a run that matters:
  // a one-run stops at the first pad zero, and a zero-run reaching the lane
  // LSB only happens for zero/NaR lanes, which are masked by the caller.
  // Returns {exp[EXP_L], mant[MANT_L]}.
  function automatic logic [EXP_L+MANT_L-1:0] decode_lane(
    input logic [W-2:0] body,
    input int           es
  );
    logic                     first;
    logic                     run;
    int                       k;
    logic [W-2:0]             rem;
    logic [ES_FULL-1:0]       es_val;
    logic [MANT_L-2:0]        frac;
    logic signed [EXP_L-1:0]  regime;
    logic [EXP_L-1:0]         exp_v;
    first = body[W-2];
    run   = 1'b1;
    k     = 0;
    for (int i = W - 2; i >= 0; i--) begin
      if (run && (body[i] == first)) k++;
      else                           run = 1'b0;
    end
    regime = first ? EXP_L'(k - 1) : EXP_L'(-k);
    // Drop regime and terminator; a shift of the full width yields zero,
    // which covers the no-terminator case and zero-fills truncated es bits.
    rem    = body << (k + 1);
    es_val = ES_FULL'(rem >> (W - 1 - es));
    frac   = (MANT_L-1)'((rem << es) >> (ES_FULL + 1));
    exp_v  = EXP_L'(regime <<< es) + EXP_L'(es_val);
    return {exp_v, 1'b1, frac};
  endfunction

  // ---------------------------------------------------------------- handshake
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  // ------------------------------------------------------------ stage 1 comb
  logic [W-1:0] abs_n;
  logic [3:0]   sign_n, zero_n, nar_n;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    abs_n  = '0;
    sign_n = '0;
    zero_n = '0;
    nar_n  = '0;
    case (bus.in_mode)
      2'd0: begin
        sign_n[0] = bus.in_data[W-1] & (|bus.in_data[W-2:0]);
        zero_n[0] = ~|bus.in_data;
        nar_n[0]  = bus.in_data[W-1] & ~(|bus.in_data[W-2:0]);
        abs_n     = bus.in_data[W-1] ? -bus.in_data : bus.in_data;
      end
      2'd1: begin
        for (int i = 0; i < 2; i++) begin
          sign_n[i] = bus.in_data[i*HW+HW-1] & (|bus.in_data[i*HW +: HW-1]);
          zero_n[i] = ~|bus.in_data[i*HW +: HW];
          nar_n[i]  = bus.in_data[i*HW+HW-1] & ~(|bus.in_data[i*HW +: HW-1]);
          abs_n[i*HW +: HW] = bus.in_data[i*HW+HW-1] ? -bus.in_data[i*HW +: HW]
                                                     : bus.in_data[i*HW +: HW];
        end
      end
      2'd2: begin
        for (int i = 0; i < 4; i++) begin
          sign_n[i] = bus.in_data[i*QW+QW-1] & (|bus.in_data[i*QW +: QW-1]);
          zero_n[i] = ~|bus.in_data[i*QW +: QW];
          nar_n[i]  = bus.in_data[i*QW+QW-1] & ~(|bus.in_data[i*QW +: QW-1]);
          abs_n[i*QW +: QW] = bus.in_data[i*QW+QW-1] ? -bus.in_data[i*QW +: QW]
                                                     : bus.in_data[i*QW +: QW];
        end
      end
      default: ;  // illegal mode: everything stays zero
    endcase
  end

  // ------------------------------------------------------------ stage 1 regs
  logic [1:0]   s1_mode;
  logic [3:0]   s1_sign, s1_zero, s1_nar;
  logic [W-1:0] s1_abs;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
    end
  end

  // NOTE: the stage-1 payload is qualified by s1_valid and never observed
  // directly, so it carries no reset; only the visible stage-2 data does.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      s1_mode <= bus.in_mode;
      s1_sign <= sign_n;
      s1_zero <= zero_n;
      s1_nar  <= nar_n;
      s1_abs  <= abs_n;
    end
  end

  // Every lane magnitude MSB is a sign position and is dropped by the decode,
  // except that only the word MSB is never reused as a body bit in any mode.
  logic unused_abs_msb;
  assign unused_abs_msb = s1_abs[W-1];

  // ------------------------------------------------------------ stage 2 comb
  logic [W-2:0]            body [4];
  logic [3:0]              active;
  int                      es_sel;
  logic [EXP_L+MANT_L-1:0] dec;
  logic [4*EXP_L-1:0]      exp_n;
  logic [4*MANT_L-1:0]     mant_n;

  always_comb begin
    for (int s = 0; s < 4; s++) body[s] = '0;
    active = 4'b0000;
    es_sel = 0;
    dec    = '0;
    exp_n  = '0;
    mant_n = '0;
    case (s1_mode)
      2'd0: begin
        body[0] = s1_abs[W-2:0];
        es_sel  = ES_FULL;
        active  = 4'b0001;
      end
      2'd1: begin
        for (int s = 0; s < 2; s++)
          body[s] = {s1_abs[s*HW +: HW-1], {(W-HW){1'b0}}};
        es_sel = ES_HALF;
        active = 4'b0011;
      end
      2'd2: begin
        for (int s = 0; s < 4; s++)
          body[s] = {s1_abs[s*QW +: QW-1], {(W-QW){1'b0}}};
        es_sel = ES_QUART;
        active = 4'b1111;
      end
      default: ;
    endcase
    for (int s = 0; s < 4; s++) begin
      dec = decode_lane(body[s], es_sel);
      if (active[s] && !s1_zero[s] && !s1_nar[s]) begin
        exp_n[s*EXP_L +: EXP_L]    = dec[MANT_L +: EXP_L];
        mant_n[s*MANT_L +: MANT_L] = dec[MANT_L-1:0];
      end
    end
  end

  // ------------------------------------------------------------ stage 2 regs
  logic [1:0]          s2_mode;
  logic [3:0]          s2_sign, s2_zero, s2_nar;
  logic [4*EXP_L-1:0]  s2_exp;
  logic [4*MANT_L-1:0] s2_mant;
  logic                s2_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_mode  <= '0;
      s2_sign  <= '0;
      s2_zero  <= '0;
      s2_nar   <= '0;
      s2_exp   <= '0;
      s2_mant  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode <= s1_mode;
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_nar  <= s1_nar;
        s2_exp  <= exp_n;
        s2_mant <= mant_n;
        s2_err  <= (s1_mode == 2'd3);
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_mode  = s2_mode;
  assign bus.out_sign  = s2_sign;
  assign bus.out_zero  = s2_zero;
  assign bus.out_nar   = s2_nar;
  assign bus.out_exp   = s2_exp;
  assign bus.out_mant  = s2_mant;
  assign bus.out_err   = s2_err;

`ifdef POSIT_DECODE_STATS_EN
  // ------------------------------------------------------------- statistics
  function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                          input logic [2:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic out_xfer;
  assign out_xfer = s2_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_zero_cnt <= '0;
      stat_nar_cnt  <= '0;
      stat_err_cnt  <= '0;
    end else if (out_xfer) begin
      stat_zero_cnt <= sat_add(stat_zero_cnt, 3'($countones(s2_zero)));
      stat_nar_cnt  <= sat_add(stat_nar_cnt, 3'($countones(s2_nar)));
      stat_err_cnt  <= sat_add(stat_err_cnt, {2'b00, s2_err});
    end
  end
`endif
endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
- Pipelined, parametrised posit field decoder for the PE datapath; successor to the combinational unsigned field extractor.
- Accepts one W-bit word per transaction, holding 1, 2 or 4 posit lanes selected per transaction by mode.
- Handles sign (two's-complement negation), zero and NaR detection.
- Produces signed exponent and hidden-bit mantissa per lane through a 2-stage valid/ready pipeline that tolerates back-pressure.

Parameters:
- W, 32, word width; must be a multiple of 8 and at least 16. Lane widths are W, W/2 and W/4.
- ES_FULL, 6, exponent-field bits in full-width mode.
- ES_HALF, 4, exponent-field bits in half-width mode.
- ES_QUART, 2, exponent-field bits in quarter-width mode.
- EXP_L, ES_FULL+$clog2(W)+1, signed exponent slot width (derived, not overridable).
- MANT_L, W-1-ES_FULL, mantissa slot width including hidden bit (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept a word this cycle
- in_data  in  W  packed posits; lane i occupies bits [(i+1)*LW-1 : i*LW]
- in_mode  in  2  0=full (1 lane), 1=half (2 lanes), 2=quarter (4 lanes), 3=illegal
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_mode  out  2  mode travelling with the result
- out_sign  out  4  per-slot sign
- out_zero  out  4  per-slot zero flag
- out_nar  out  4  per-slot NaR flag
- out_exp  out  4*EXP_L  per-slot signed exponent = regime*2^ES + es_bits
- out_mant  out  4*MANT_L  per-slot mantissa, hidden bit at MSB, MSB-justified
- out_err  out  1  transaction carried illegal mode

Behaviour:
- Reset: rst is sampled on clk only. It clears both stage-valid bits. All outputs read 0, and in_ready reads 1 the cycle after reset.
- A reset in mid-flight discards in-flight words without emitting them.
- Stage 1 registers mode, sign bits, zero/NaR flags and the per-lane absolute value. The absolute value is the two's complement of a lane when its sign is 1.
- Stage 2 performs a decomposable leading-run detect on each lane (excluding the sign bit), then a left shift past regime and terminator. It registers exponent and mantissa.
- Latency: 2 cycles from an accepted input to out_valid when out_ready stays high. Throughput is 1 word per cycle.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - Stage 2 advances when it is empty or out_ready=1. Stage 1 advances when it is empty or stage 2 advances.
  - in_ready = ~s1_valid | s2_adv (combinational).
  - While out_valid && ~out_ready, all out_* hold stable.
- Regime: a run of k ones gives regime k-1; a run of k zeros gives regime -k.
  - A run that reaches the lane LSB has no terminator; es and fraction bits are then 0.
  - es bits truncated by a long regime are zero-filled at the LSB.
- Slot mapping: slot i = lane i. Unused slots (i ≥ lane count) output all zeros.
  - In narrower modes the mantissa, LW-1-ES bits, is MSB-justified in MANT_L and zero-padded at the LSB.
  - The exponent is sign-extended to EXP_L.
- Zero lane (all bits 0): zero=1, sign=0, exp=0, mant=0.
- NaR lane (MSB 1, rest 0): nar=1, sign=0, exp=0, mant=0. The hidden bit is not set.
- Illegal mode 3: the word is accepted and flows through normally with out_err=1. All slot outputs and flags are 0.
- Mode may change on every transaction; no pipeline flush is needed.

Optional Feature:
- Macro POSIT_DECODE_STATS_EN.
- When defined, adds the following outputs, all cleared by rst:
  - stat_zero_cnt (16b): saturating count of zero lanes, counted at the out transfer.
  - stat_nar_cnt (16b): saturating count of NaR lanes, counted at the out transfer.
  - stat_err_cnt (16b): saturating count of illegal-mode transactions, counted at the out transfer.
- The counters saturate at 0xFFFF without wrap.
- When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Full mode (defaults), in_data=0x40000000 -> 2 cycles later: sign=0, exp[0]=0, mant[0]=0x1000000, slots 1-3 all zero.
- Full mode, 0xC0000000 -> sign[0]=1, exp[0]=0, mant[0]=0x1000000. Full mode, 0x80000000 -> nar[0]=1, exp=mant=0.
- Quarter mode, 0x40000080 -> slot3: exp 0, mant 0x1000000; slot2 and slot1: zero=1; slot0: nar=1.
- Quarter mode, 0x00000070 -> slot0: exp=8, mant=0x1000000; slots 1-3: zero=1.
- Back-pressure: out_ready=0, push 3 words back-to-back -> 2 words accepted, in_ready=0 on the third, outputs stable. Release out_ready -> results emerge in order with no loss or duplication.
- Illegal mode 3 -> out_err=1 with all slots 0. Then assert rst while 2 words are in flight -> out_valid=0 next cycle and nothing is emitted. With POSIT_DECODE_STATS_EN, the counters read 0 after reset.
